// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) beside the EX stage.
// One quotient bit per cycle; result_o = {remainder, quotient}; annul_i aborts.
module div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_FREE   = 2'b00,
    S_BYZERO = 2'b01,
    S_ON     = 2'b10,
    S_END    = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               signed_q, signed_d;
  logic               sign1_q, sign1_d;
  logic               sign2_q, sign2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      signed_q <= 1'b0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvsr_q   <= dvsr_d;
      signed_q <= signed_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state, iteration step and registered-output values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvsr_d   = dvsr_q;
    signed_d = signed_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    result_d = result_q;
    ready_d  = ready_q;

    // Quotient register initially holds the dividend magnitude; its MSB feeds the remainder
    shifted  = {rem_q, quot_q[WIDTH-1]};
    abs1     = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    abs2     = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
    quot_fix = (signed_q && (sign1_q ^ sign2_q)) ? (~quot_q + WIDTH'(1)) : quot_q;
    rem_fix  = (signed_q && sign1_q) ? (~rem_q + WIDTH'(1)) : rem_q;

    unique case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d  = S_ON;
            cnt_d    = '0;
            rem_d    = '0;
            quot_d   = abs1;
            dvsr_d   = abs2;
            signed_d = signed_div_i;
            sign1_d  = opdata1_i[WIDTH-1];
            sign2_d  = opdata2_i[WIDTH-1];
          end
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else begin
          state_d  = S_END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_FREE;
        end else if (cnt_q < CNT_W'(WIDTH)) begin
          if (shifted >= {1'b0, dvsr_q}) begin
            rem_d  = shifted[WIDTH-1:0] - dvsr_q;
            quot_d = {quot_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d  = shifted[WIDTH-1:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d  = S_END;
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
        end
      end
      S_END: begin
        // Result held until EX drops start; annul is not honoured here
        if (!start_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed scenarios plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  div #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: truncating division on widened integers, {rem, quot}; zero divisor -> 0
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    if (b == 32'h0) return 64'h0;
    la = sgn ? longint'($signed(a)) : longint'({32'h0, a});
    lb = sgn ? longint'($signed(b)) : longint'({32'h0, b});
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one op and wait for ready; lat = edges after the sampling edge (0 on timeout)
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    lat = 0;
    res = 64'h0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        lat = k;
        res = result_o;
        break;
      end
    end
  endtask

  task automatic drop_start();
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'h0; opdata2_i = 32'h0;
    #12;
    total_cnt++;
    if (ready_o !== 1'b0 || result_o !== 64'h0)
      $display("FAIL reset: ready=%b result=%h required ready=0 result=0", ready_o, result_o);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [63:0] res;
    int lat;
    run_op(1'b0, 32'd7, 32'd2, res, lat);
    total_cnt++;
    if (lat !== 33) $display("FAIL divu_latency: got %0d required 33", lat);
    else pass_cnt++;
    total_cnt++;
    if (res !== {32'h1, 32'h3}) $display("FAIL divu_7_2: got %h required %h", res, {32'h1, 32'h3});
    else pass_cnt++;
    drop_start();
    run_op(1'b1, 32'hFFFFFFF9, 32'h2, res, lat);
    total_cnt++;
    if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD} || lat !== 33)
      $display("FAIL div_m7_2: got %h lat %0d required %h lat 33", res, lat, {32'hFFFFFFFF, 32'hFFFFFFFD});
    else pass_cnt++;
    drop_start();
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, res, lat);
    total_cnt++;
    if (res !== {32'h1, 32'hFFFFFFFD} || lat !== 33)
      $display("FAIL div_7_m2: got %h lat %0d required %h lat 33", res, lat, {32'h1, 32'hFFFFFFFD});
    else pass_cnt++;
    drop_start();
  endtask

  task automatic test_div_by_zero();
    logic [63:0] res;
    int lat;
    for (int s = 0; s < 2; s++) begin
      run_op(s[0], 32'h12345678, 32'h0, res, lat);
      total_cnt++;
      if (lat !== 1 || res !== 64'h0)
        $display("FAIL byzero_s%0d: lat %0d result %h required lat 1 result 0", s, lat, res);
      else pass_cnt++;
      drop_start();
    end
  endtask

  task automatic test_annul();
    logic [63:0] res;
    int lat;
    int seen;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'hDEADBEEF; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (ready_o) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL annul_no_ready: ready high %0d cycles required 0", seen);
    else pass_cnt++;
    run_op(1'b0, 32'd100, 32'd7, res, lat);
    total_cnt++;
    if (res !== {32'h2, 32'hE} || lat !== 33)
      $display("FAIL after_annul_100_7: got %h lat %0d required %h lat 33", res, lat, {32'h2, 32'hE});
    else pass_cnt++;
    drop_start();
    // start and annul together in FREE must not launch an op
    @(negedge clk);
    opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
    repeat (3) @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (ready_o) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL start_annul_free: ready high %0d cycles required 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] res;
    logic [63:0] exp;
    int lat;
    int bad;
    run_op(1'b0, 32'd1000, 32'd33, res, lat);
    exp = ref_div(1'b0, 32'd1000, 32'd33);
    total_cnt++;
    if (res !== exp || lat !== 33) $display("FAIL hold_first: got %h lat %0d required %h lat 33", res, lat, exp);
    else pass_cnt++;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b1 || result_o !== exp) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL hold_stable: %0d unstable cycles required 0", bad);
    else pass_cnt++;
    drop_start();
    @(posedge clk); #1;
    total_cnt++;
    if (ready_o !== 1'b0 || result_o !== 64'h0)
      $display("FAIL drop_clears: ready=%b result=%h required ready=0 result=0", ready_o, result_o);
    else pass_cnt++;
    run_op(1'b1, 32'hFFFFFF9C, 32'd9, res, lat);
    exp = ref_div(1'b1, 32'hFFFFFF9C, 32'd9);
    total_cnt++;
    if (res !== exp || lat !== 33) $display("FAIL back_to_back: got %h lat %0d required %h lat 33", res, lat, exp);
    else pass_cnt++;
    drop_start();
  endtask

  task automatic test_async_reset();
    logic [63:0] res;
    int lat;
    run_op(1'b0, 32'd77, 32'd5, res, lat);
    #2;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (ready_o !== 1'b0 || result_o !== 64'h0)
      $display("FAIL async_reset_end: ready=%b result=%h required ready=0 result=0", ready_o, result_o);
    else pass_cnt++;
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    // reset again mid-iteration, then a fresh op must run with full latency
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd999; opdata2_i = 32'd4; start_i = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, res, lat);
    total_cnt++;
    if (res !== {32'h0, 32'h80000000} || lat !== 33)
      $display("FAIL overflow_after_reset: got %h lat %0d required %h lat 33", res, lat, {32'h0, 32'h80000000});
    else pass_cnt++;
    drop_start();
  endtask

  task automatic test_random();
    logic [63:0] res;
    logic [63:0] exp;
    logic [31:0] a, b;
    logic        sgn;
    int lat;
    int exp_lat;
    for (int n = 0; n < 1000; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      exp     = ref_div(sgn, a, b);
      exp_lat = (b == 32'h0) ? 1 : 33;
      run_op(sgn, a, b, res, lat);
      total_cnt++;
      if (res !== exp || lat !== exp_lat)
        $display("FAIL random[%0d] s=%b %h/%h: got %h lat %0d required %h lat %0d",
                 n, sgn, a, b, res, lat, exp, exp_lat);
      else pass_cnt++;
      drop_start();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_by_zero();
    test_annul();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
